// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit static pipeline.
// Non-memory instructions pass straight to WB in one cycle. LOAD and STORE
// (with mem_wena set) are issued to the data memory through a req/ready
// handshake, and the stage stalls upstream until the access completes.
//
// Handshake: dmem_req rises on the edge that samples a memory op and stays
// high until an exec edge samples dmem_ready=1. That edge completes the
// access and drops dmem_req. dmem_ready is ignored outside WAIT and while
// cpu_state=0.
module mem_stage #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_state,
  input  logic [15:0]       mem_instr,
  input  logic [15:0]       mem_alu_result,
  input  logic [15:0]       mem_store_data,
  input  logic              mem_wena,
  input  logic              zf_in,
  input  logic              nf_in,
  input  logic              cf_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic [15:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic              mem_stall,
  output logic [15:0]       wb_instr,
  output logic [15:0]       wb_result,
  output logic              wb_reg_we,
  output logic              wb_zf,
  output logic              wb_nf,
  output logic              wb_cf
);

  localparam logic [3:0]  OP_ADD   = 4'b0010;
  localparam logic [3:0]  OP_LOAD  = 4'b1101;
  localparam logic [3:0]  OP_STORE = 4'b1110;
  localparam logic [15:0] NOP      = 16'h0000;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]  opcode;
  logic        is_load;
  logic        is_store;
  logic        is_mem;

  // Instruction, flags and store data of the access in flight
  logic [15:0] hold_instr;
  logic [15:0] hold_data;
  logic        hold_zf;
  logic        hold_nf;
  logic        hold_cf;

  assign opcode   = mem_instr[15:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE) && mem_wena;
  assign is_mem   = is_load || is_store;

  // The stall is the externally visible FSM state (high exactly in WAIT)
  assign mem_stall = (state == WAIT);

  // State register; frozen while the CPU is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else if (cpu_state) begin
      state <= state_nxt;
    end
  end

  // Next state: enter WAIT on an issued access, leave it on ready
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (is_mem) state_nxt = WAIT;
      WAIT:    if (dmem_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Memory request, hold registers and WB outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_instr   <= NOP;
      wb_result  <= '0;
      wb_reg_we  <= 1'b0;
      wb_zf      <= 1'b0;
      wb_nf      <= 1'b0;
      wb_cf      <= 1'b0;
      hold_instr <= NOP;
      hold_data  <= '0;
      hold_zf    <= 1'b0;
      hold_nf    <= 1'b0;
      hold_cf    <= 1'b0;
    end else if (cpu_state) begin
      if (state == RUN) begin
        if (is_mem) begin
          // Issue the access and send a bubble down while it is outstanding
          hold_instr <= mem_instr;
          hold_data  <= mem_store_data;
          hold_zf    <= zf_in;
          hold_nf    <= nf_in;
          hold_cf    <= cf_in;
          dmem_req   <= 1'b1;
          dmem_we    <= is_store;
          dmem_addr  <= mem_instr[ADDR_W-1:0];
          if (is_store) dmem_wdata <= mem_store_data;
          wb_instr   <= NOP;
          wb_reg_we  <= 1'b0;
          wb_zf      <= 1'b0;
          wb_nf      <= 1'b0;
          wb_cf      <= 1'b0;
        end else begin
          // Pass-through, including STORE without mem_wena and unknown opcodes
          wb_instr  <= mem_instr;
          wb_result <= mem_alu_result;
          wb_reg_we <= (opcode == OP_ADD);
          wb_zf     <= zf_in;
          wb_nf     <= nf_in;
          wb_cf     <= cf_in;
        end
      end else if (dmem_ready) begin
        // Complete the access and retire the held instruction
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
        wb_instr <= hold_instr;
        wb_zf    <= hold_zf;
        wb_nf    <= hold_nf;
        wb_cf    <= hold_cf;
        if (hold_instr[15:12] == OP_LOAD) begin
          wb_result <= dmem_rdata;
          wb_reg_we <= 1'b1;
        end else begin
          wb_result <= hold_data;
          wb_reg_we <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction-level check of mem_stage.
// Each instruction is issued as one transaction; the bench plays the data
// memory (random wait and idle cycles) and predicts the WB result from the
// instruction rules directly.
module tb_mem_stage;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_state;
  logic [15:0]       mem_instr;
  logic [15:0]       mem_alu_result;
  logic [15:0]       mem_store_data;
  logic              mem_wena;
  logic              zf_in, nf_in, cf_in;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [15:0]       dmem_wdata;
  logic [15:0]       dmem_rdata;
  logic              dmem_ready;
  logic              mem_stall;
  logic [15:0]       wb_instr;
  logic [15:0]       wb_result;
  logic              wb_reg_we;
  logic              wb_zf, wb_nf, wb_cf;

  int total = 0;
  int bad   = 0;

  // Last retired WB values, used to check that idle cycles freeze the stage
  logic [15:0] last_instr;
  logic [15:0] last_result;
  logic        last_we;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .cpu_state(cpu_state),
    .mem_instr(mem_instr), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_wena(mem_wena),
    .zf_in(zf_in), .nf_in(nf_in), .cf_in(cf_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .wb_instr(wb_instr), .wb_result(wb_result),
    .wb_reg_we(wb_reg_we), .wb_zf(wb_zf), .wb_nf(wb_nf), .wb_cf(wb_cf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs the stage must ignore (WAIT cycles, idle cycles)
  task automatic scramble_inputs();
    mem_instr      = 16'($urandom);
    mem_alu_result = 16'($urandom);
    mem_store_data = 16'($urandom);
    mem_wena       = 1'($urandom);
    {zf_in, nf_in, cf_in} = 3'($urandom);
    dmem_rdata     = 16'($urandom);
  endtask

  // One instruction as a full transaction. waits = exec cycles with ready low,
  // idles = cpu_state=0 cycles (with ready high) before completion.
  task automatic do_op(input logic [15:0] instr, input logic [15:0] alu,
                       input logic [15:0] sd, input logic wena,
                       input logic [2:0] fl, input logic [15:0] rd,
                       input int waits, input int idles);
    logic [3:0] opc;
    logic       ld, st;
    opc = instr[15:12];
    ld  = (opc == 4'hD);
    st  = (opc == 4'hE) && wena;
    cpu_state      = 1'b1;
    mem_instr      = instr;
    mem_alu_result = alu;
    mem_store_data = sd;
    mem_wena       = wena;
    {zf_in, nf_in, cf_in} = fl;
    dmem_ready     = 1'($urandom);
    dmem_rdata     = 16'($urandom);
    @(posedge clk); #1;
    if (!(ld || st)) begin
      chk("pass_instr", wb_instr, instr);
      chk("pass_result", wb_result, alu);
      chk("pass_we", 16'(wb_reg_we), 16'(opc == 4'h2));
      chk("pass_flags", 16'({wb_zf, wb_nf, wb_cf}), 16'(fl));
      chk("pass_req", 16'(dmem_req), 16'h0);
      chk("pass_stall", 16'(mem_stall), 16'h0);
      last_instr = instr; last_result = alu; last_we = (opc == 4'h2);
      return;
    end
    chk("issue_req", 16'(dmem_req), 16'h1);
    chk("issue_we", 16'(dmem_we), 16'(st));
    chk("issue_addr", 16'(dmem_addr), 16'(instr[ADDR_W-1:0]));
    if (st) chk("issue_wdata", dmem_wdata, sd);
    chk("issue_stall", 16'(mem_stall), 16'h1);
    chk("bubble_instr", wb_instr, 16'h0000);
    chk("bubble_we", 16'(wb_reg_we), 16'h0);
    for (int i = 0; i < idles + waits; i++) begin
      scramble_inputs();
      cpu_state  = (i >= idles);
      dmem_ready = (i < idles);
      @(posedge clk); #1;
      chk("wait_req", 16'(dmem_req), 16'h1);
      chk("wait_stall", 16'(mem_stall), 16'h1);
      chk("wait_instr", wb_instr, 16'h0000);
    end
    scramble_inputs();
    cpu_state  = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = rd;
    @(posedge clk); #1;
    chk("done_req", 16'(dmem_req), 16'h0);
    chk("done_stall", 16'(mem_stall), 16'h0);
    chk("done_instr", wb_instr, instr);
    chk("done_result", wb_result, ld ? rd : sd);
    chk("done_we", 16'(wb_reg_we), 16'(ld));
    chk("done_flags", 16'({wb_zf, wb_nf, wb_cf}), 16'(fl));
    last_instr = instr; last_result = ld ? rd : sd; last_we = ld;
  endtask

  // An idle cycle in RUN must leave WB untouched
  task automatic idle_cycle();
    scramble_inputs();
    cpu_state  = 1'b0;
    dmem_ready = 1'($urandom);
    @(posedge clk); #1;
    chk("idle_instr", wb_instr, last_instr);
    chk("idle_result", wb_result, last_result);
    chk("idle_we", 16'(wb_reg_we), 16'(last_we));
    chk("idle_req", 16'(dmem_req), 16'h0);
  endtask

  initial begin
    logic [15:0] ins;
    logic [3:0]  pick [0:7];
    pick[0] = 4'h0; pick[1] = 4'h1; pick[2] = 4'h2; pick[3] = 4'h7;
    pick[4] = 4'h9; pick[5] = 4'hB; pick[6] = 4'hD; pick[7] = 4'hE;

    // Reset
    reset = 1'b1;
    cpu_state = 1'b0;
    scramble_inputs();
    dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 16'(dmem_req), 16'h0);
    chk("rst_we", 16'(dmem_we), 16'h0);
    chk("rst_addr", 16'(dmem_addr), 16'h0);
    chk("rst_wdata", dmem_wdata, 16'h0);
    chk("rst_stall", 16'(mem_stall), 16'h0);
    chk("rst_instr", wb_instr, 16'h0000);
    chk("rst_result", wb_result, 16'h0);
    chk("rst_flags", 16'({wb_reg_we, wb_zf, wb_nf, wb_cf}), 16'h0);
    reset = 1'b0;
    last_instr = 16'h0; last_result = 16'h0; last_we = 1'b0;

    // Directed cases
    do_op(16'h2123, 16'h00FF, 16'h0, 1'b0, 3'b000, 16'h0, 0, 0);
    do_op(16'hD105, 16'h0, 16'h0, 1'b0, 3'b010, 16'hBEEF, 0, 0);
    do_op(16'hE20A, 16'h0, 16'h1234, 1'b1, 3'b101, 16'h0, 3, 0);
    do_op(16'hE20A, 16'h5555, 16'h1234, 1'b0, 3'b001, 16'h0, 0, 0);
    do_op(16'hD1F0, 16'h0, 16'h0, 1'b0, 3'b100, 16'hCAFE, 1, 2);
    do_op(16'h7ABC, 16'h0001, 16'h0, 1'b0, 3'b111, 16'h0, 0, 0);
    do_op(16'h5ABC, 16'h0002, 16'h0, 1'b0, 3'b011, 16'h0, 0, 0);
    idle_cycle();

    // Reset while an access is outstanding aborts it immediately
    cpu_state  = 1'b1;
    mem_instr  = 16'hD1AA;
    mem_wena   = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_pre_stall", 16'(mem_stall), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_req", 16'(dmem_req), 16'h0);
    chk("abort_stall", 16'(mem_stall), 16'h0);
    chk("abort_instr", wb_instr, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    last_instr = 16'h0; last_result = 16'h0; last_we = 1'b0;
    idle_cycle();

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ins[15:12] = pick[$urandom_range(0, 7)];
      do_op(ins, 16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
            16'($urandom), $urandom_range(0, 3), $urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
